// File: rtl/ibuf_pkg.sv
// Shared types for the per-warp instruction buffer: ID widths, replay FSM states and the FIFO entry.
package ibuf_pkg;

  localparam int unsigned REG_ID_W   = 5;
  localparam int unsigned SCBID_W    = 2;
  localparam int unsigned IB_INSTR_W = 32;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_MEM = 2'd1,
    REPLAY   = 2'd2
  } rpl_state_e;

  typedef struct packed {
    logic [IB_INSTR_W-1:0] instr;
    logic [REG_ID_W-1:0]   src1;
    logic [REG_ID_W-1:0]   src2;
    logic [REG_ID_W-1:0]   dst;
    logic                  src1_valid;
    logic                  src2_valid;
    logic                  dst_valid;
    logic                  replayable;
    logic                  sw_lwbar;
  } ib_entry_t;

endpackage

// File: rtl/ibuf_fifo.sv
// DEPTH x ib_entry_t synchronous FIFO; head is zeroed when empty.
// IBUF_FLUSH_EN adds a synchronous clear that also suppresses that cycle's push.
module ibuf_fifo
  import ibuf_pkg::*;
#(
  parameter int unsigned DEPTH     = 4,
  parameter int unsigned LOG_DEPTH = $clog2(DEPTH)
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      push_i,
  input  logic      pop_i,
`ifdef IBUF_FLUSH_EN
  input  logic      clear_i,
`endif
  input  ib_entry_t din_i,
  output ib_entry_t head_o,
  output logic      full_o,
  output logic      empty_o
);

  ib_entry_t            mem_q [DEPTH];
  logic [LOG_DEPTH-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [LOG_DEPTH:0]   cnt_q, cnt_d;
  logic                 push_ok, pop_ok;

  assign full_o  = (cnt_q == (LOG_DEPTH+1)'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign pop_ok  = pop_i & ~empty_o;
  // A full FIFO still accepts a push when the head leaves in the same cycle.
`ifdef IBUF_FLUSH_EN
  assign push_ok = push_i & (~full_o | pop_i) & ~clear_i;
`else
  assign push_ok = push_i & (~full_o | pop_i);
`endif

  always_comb begin
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q + (LOG_DEPTH+1)'(push_ok) - (LOG_DEPTH+1)'(pop_ok);
    if (push_ok) wr_d = wr_q + LOG_DEPTH'(1);
    if (pop_ok)  rd_d = rd_q + LOG_DEPTH'(1);
`ifdef IBUF_FLUSH_EN
    if (clear_i) begin
      wr_d  = '0;
      rd_d  = '0;
      cnt_d = '0;
    end
`endif
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_q] <= din_i;
  end

  assign head_o = empty_o ? '0 : mem_q[rd_q];

endmodule

// File: rtl/ibuffer_warp.sv
// Per-warp instruction buffer: FIFO ahead of the scoreboard, issue register and LW/SW replay slot.
// IBUF_FLUSH_EN adds a flush input that empties the FIFO.
module ibuffer_warp
  import ibuf_pkg::*;
#(
  parameter int unsigned DEPTH     = 4,
  parameter int unsigned INSTR_W   = 32,
  parameter int unsigned LOG_DEPTH = $clog2(DEPTH)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                dec_valid,
  input  logic [INSTR_W-1:0]  dec_instr,
  input  logic [REG_ID_W-1:0] dec_src1,
  input  logic [REG_ID_W-1:0] dec_src2,
  input  logic [REG_ID_W-1:0] dec_dst,
  input  logic                dec_src1_valid,
  input  logic                dec_src2_valid,
  input  logic                dec_dst_valid,
  input  logic                dec_replayable,
  input  logic                dec_SW_LWbar,
`ifdef IBUF_FLUSH_EN
  input  logic                flush,
`endif
  output logic                full_IB_Dec,
  output logic [REG_ID_W-1:0] src1,
  output logic [REG_ID_W-1:0] src2,
  output logic [REG_ID_W-1:0] dst,
  output logic                src1_valid,
  output logic                src2_valid,
  output logic                dst_valid,
  output logic                replayable,
  input  logic                full_Scb_IB,
  input  logic                dependent_Scb_IB,
  input  logic [SCBID_W-1:0]  ScbID_Scb_IB,
  output logic                RP_req_IB,
  output logic                Rpl_req_IB,
  input  logic                RP_grt,
  input  logic                Rpl_grt,
  output logic                RP_grt_IB_Scb,
  output logic                issue_valid_IB_OC,
  output logic [INSTR_W-1:0]  issue_instr_IB_OC,
  output logic [SCBID_W-1:0]  issue_ScbID_IB_OC,
  input  logic                mem_replay,
  input  logic                mem_done,
  output logic                replay_complete,
  output logic [SCBID_W-1:0]  replay_complete_ScbID,
  output logic                replay_SW_LWbar
);

  ib_entry_t           din, head;
  logic                empty;
  rpl_state_e          state_q, state_d;
  logic [INSTR_W-1:0]  slot_instr_q, slot_instr_d;
  logic [SCBID_W-1:0]  slot_scbid_q, slot_scbid_d;
  logic                slot_sw_q, slot_sw_d;
  logic                issue_valid_q, issue_valid_d;
  logic [INSTR_W-1:0]  issue_instr_q, issue_instr_d;
  logic [SCBID_W-1:0]  issue_scbid_q, issue_scbid_d;

  always_comb begin
    din            = '0;
    din.instr      = IB_INSTR_W'(dec_instr);
    din.src1       = dec_src1;
    din.src2       = dec_src2;
    din.dst        = dec_dst;
    din.src1_valid = dec_src1_valid;
    din.src2_valid = dec_src2_valid;
    din.dst_valid  = dec_dst_valid;
    din.replayable = dec_replayable;
    din.sw_lwbar   = dec_SW_LWbar;
  end

  ibuf_fifo #(
    .DEPTH     (DEPTH),
    .LOG_DEPTH (LOG_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (dec_valid),
    .pop_i   (RP_grt),
`ifdef IBUF_FLUSH_EN
    .clear_i (flush),
`endif
    .din_i   (din),
    .head_o  (head),
    .full_o  (full_IB_Dec),
    .empty_o (empty)
  );

  assign src1       = head.src1;
  assign src2       = head.src2;
  assign dst        = head.dst;
  assign src1_valid = head.src1_valid;
  assign src2_valid = head.src2_valid;
  assign dst_valid  = head.dst_valid;
  assign replayable = head.replayable;

  // A second LW/SW cannot issue while the single replay slot is occupied.
`ifdef IBUF_FLUSH_EN
  assign RP_req_IB = ~empty & ~full_Scb_IB & ~dependent_Scb_IB &
                     ~(head.replayable & (state_q != IDLE)) & ~flush;
`else
  assign RP_req_IB = ~empty & ~full_Scb_IB & ~dependent_Scb_IB &
                     ~(head.replayable & (state_q != IDLE));
`endif

  assign Rpl_req_IB            = (state_q == REPLAY);
  assign RP_grt_IB_Scb         = RP_grt;
  assign replay_complete       = (state_q == WAIT_MEM) & mem_done;
  assign replay_complete_ScbID = replay_complete ? slot_scbid_q : '0;
  assign replay_SW_LWbar       = replay_complete & slot_sw_q;

  assign issue_valid_IB_OC = issue_valid_q;
  assign issue_instr_IB_OC = issue_instr_q;
  assign issue_ScbID_IB_OC = issue_scbid_q;

  always_comb begin
    state_d       = state_q;
    slot_instr_d  = slot_instr_q;
    slot_scbid_d  = slot_scbid_q;
    slot_sw_d     = slot_sw_q;
    issue_valid_d = 1'b0;
    issue_instr_d = '0;
    issue_scbid_d = '0;

    if (RP_grt) begin
      issue_valid_d = 1'b1;
      issue_instr_d = INSTR_W'(head.instr);
      issue_scbid_d = ScbID_Scb_IB;
    end else if (Rpl_grt && state_q == REPLAY) begin
      issue_valid_d = 1'b1;
      issue_instr_d = slot_instr_q;
      issue_scbid_d = slot_scbid_q;
    end

    case (state_q)
      IDLE: begin
        if (RP_grt && head.replayable) begin
          state_d      = WAIT_MEM;
          slot_instr_d = INSTR_W'(head.instr);
          slot_scbid_d = ScbID_Scb_IB;
          slot_sw_d    = head.sw_lwbar;
        end
      end
      WAIT_MEM: begin
        if (mem_done)        state_d = IDLE;
        else if (mem_replay) state_d = REPLAY;
      end
      REPLAY: begin
        if (Rpl_grt) state_d = WAIT_MEM;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= IDLE;
      slot_instr_q  <= '0;
      slot_scbid_q  <= '0;
      slot_sw_q     <= 1'b0;
      issue_valid_q <= 1'b0;
      issue_instr_q <= '0;
      issue_scbid_q <= '0;
    end else begin
      state_q       <= state_d;
      slot_instr_q  <= slot_instr_d;
      slot_scbid_q  <= slot_scbid_d;
      slot_sw_q     <= slot_sw_d;
      issue_valid_q <= issue_valid_d;
      issue_instr_q <= issue_instr_d;
      issue_scbid_q <= issue_scbid_d;
    end
  end

endmodule
